// File: rtl/io_port_ctrl.sv
// Memory-mapped IO port: tx byte FIFO toward the UART, rx byte pickup,
// a free-running cycle counter with snapshot readout, and a sticky stop flag.
module io_port_ctrl #(
    parameter int FIFO_AW     = 4,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  io_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        prog_done
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW+1:0] LP_DEPTH  = DEPTH[FIFO_AW+1:0];
    localparam logic [FIFO_AW+1:0] LP_MARGIN = FULL_MARGIN[FIFO_AW+1:0];
    localparam logic [17:0] A_DATA = 18'h30000;
    localparam logic [17:0] A_CTRL = 18'h30004;
    localparam logic [17:0] A_SNP1 = 18'h30005;
    localparam logic [17:0] A_SNP2 = 18'h30006;
    localparam logic [17:0] A_SNP3 = 18'h30007;

    logic [7:0]       r_mem [DEPTH];
    logic [FIFO_AW:0] r_wp, r_rp;
    logic [31:0]      r_cnt, r_snap;
    logic [7:0]       r_io_din;
    logic             r_bfull, r_done;

    logic [17:0]        w_addr;
    logic               w_io, w_rd, w_wr, w_push_req, w_push, w_pop;
    logic               w_empty, w_full;
    logic [7:0]         w_push_data;
    logic [FIFO_AW:0]   w_wp_n, w_rp_n, w_occ_n;
    logic [FIFO_AW+1:0] w_free_n;
    logic               w_unused_hi;

    assign w_unused_hi = &{1'b0, mem_a[31:18]};
    assign w_addr = mem_a[17:0];
    assign w_io   = rdy_in && (mem_a[17:16] == 2'b11);
    assign w_rd   = w_io && !mem_wr;
    assign w_wr   = w_io && mem_wr && !r_done;

    // The stop write always enqueues a 0x00 marker; ordinary zero bytes are filtered.
    assign w_push_req  = w_wr && (((w_addr == A_DATA) && (mem_dout != 8'h00)) || (w_addr == A_CTRL));
    assign w_push_data = (w_addr == A_CTRL) ? 8'h00 : mem_dout;

    assign w_empty  = (r_wp == r_rp);
    assign w_full   = (r_wp[FIFO_AW] != r_rp[FIFO_AW]) && (r_wp[FIFO_AW-1:0] == r_rp[FIFO_AW-1:0]);
    assign tx_valid = !w_empty;
    assign tx_data  = r_mem[r_rp[FIFO_AW-1:0]];
    assign w_pop    = tx_valid && tx_ready;
    assign w_push   = w_push_req && (!w_full || w_pop);

    assign w_wp_n   = r_wp + {{FIFO_AW{1'b0}}, w_push};
    assign w_rp_n   = r_rp + {{FIFO_AW{1'b0}}, w_pop};
    assign w_occ_n  = w_wp_n - w_rp_n;
    assign w_free_n = LP_DEPTH - {1'b0, w_occ_n};

    assign rx_pop         = !rst_in && w_rd && (w_addr == A_DATA) && rx_valid;
    assign io_din         = r_io_din;
    assign io_buffer_full = r_bfull;
    assign prog_done      = r_done;

    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wp[FIFO_AW-1:0]] <= w_push_data;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
            r_snap   <= '0;
            r_io_din <= '0;
            r_bfull  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_wp    <= w_wp_n;
            r_rp    <= w_rp_n;
            r_cnt   <= r_cnt + 32'd1;
            r_bfull <= (w_free_n <= LP_MARGIN);
            if (w_wr && (w_addr == A_CTRL)) r_done <= 1'b1;
            if (w_rd) begin
                case (w_addr)
                    A_DATA:  r_io_din <= rx_valid ? rx_data : 8'h00;
                    A_CTRL: begin
                        r_snap   <= r_cnt;
                        r_io_din <= r_cnt[7:0];
                    end
                    A_SNP1:  r_io_din <= r_snap[15:8];
                    A_SNP2:  r_io_din <= r_snap[23:16];
                    A_SNP3:  r_io_din <= r_snap[31:24];
                    default: r_io_din <= 8'h00;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_io_port_ctrl.sv
// Bench for io_port_ctrl: directed tables and sequences plus random traffic
// checked against a queue-based model of the port.
module tb_io_port_ctrl;
    localparam int DEPTH  = 16;
    localparam int MARGIN = 2;

    logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b0, mem_wr = 1'b0;
    logic        tx_ready = 1'b0, rx_valid = 1'b0;
    logic [31:0] mem_a = '0;
    logic [7:0]  mem_dout = '0, rx_data = '0;
    logic [7:0]  io_din, tx_data;
    logic        io_buffer_full, tx_valid, rx_pop, prog_done;

    io_port_ctrl #(.FIFO_AW(4), .FULL_MARGIN(MARGIN)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
        .mem_dout(mem_dout), .mem_wr(mem_wr), .io_din(io_din),
        .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_pop(rx_pop), .prog_done(prog_done)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rdy;
        logic [31:0] a;
        logic        wr;
        logic        rxv;
        logic [7:0]  rxd;
        logic        exp_pop;
        logic [7:0]  exp_din;
    } vec_t;
    vec_t tbl[8];

    int nvec = 0, nerr = 0;
    logic [7:0]  q[$];
    logic [7:0]  got[$];
    logic        m_done, m_bfull, last_pop;
    logic [31:0] m_cnt, m_snap;
    logic [7:0]  m_din;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_done = 1'b0; m_bfull = 1'b0; m_cnt = '0; m_snap = '0; m_din = '0;
    endtask

    // One clock cycle: called at a falling edge, returns at the next falling edge.
    task automatic step(input logic rdy, input logic [31:0] a, input logic wr, input logic [7:0] d,
                        input logic txr, input logic rxv, input logic [7:0] rxd);
        logic io, pop, push;
        logic [7:0] pd;
        logic [17:0] a18;
        int sz;
        rdy_in = rdy; mem_a = a; mem_wr = wr; mem_dout = d;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        #1;
        a18 = a[17:0];
        io  = rdy && (a[17:16] == 2'b11);
        sz  = q.size();
        chk("tx_valid", tx_valid, sz != 0);
        if (sz != 0) chk("tx_data", tx_data, q[0]);
        chk("rx_pop", rx_pop, io && !wr && (a18 == 18'h30000) && rxv);
        chk("io_din", io_din, m_din);
        chk("io_buffer_full", io_buffer_full, m_bfull);
        chk("prog_done", prog_done, m_done);
        last_pop = rx_pop;
        if (tx_valid && txr) got.push_back(tx_data);
        pop = (sz != 0) && txr;
        push = 1'b0; pd = 8'h00;
        if (io && wr && !m_done) begin
            if (a18 == 18'h30000 && d != 8'h00) begin push = 1'b1; pd = d; end
            else if (a18 == 18'h30004) begin push = 1'b1; m_done = 1'b1; end
        end
        if (io && !wr) begin
            case (a18)
                18'h30000: m_din = rxv ? rxd : 8'h00;
                18'h30004: begin m_snap = m_cnt; m_din = m_cnt[7:0]; end
                18'h30005: m_din = m_snap[15:8];
                18'h30006: m_din = m_snap[23:16];
                18'h30007: m_din = m_snap[31:24];
                default:   m_din = 8'h00;
            endcase
        end
        if (pop) void'(q.pop_front());
        if (push && (sz < DEPTH || pop)) q.push_back(pd);
        m_cnt++;
        m_bfull = ((DEPTH - q.size()) <= MARGIN);
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic idle(input logic txr);
        step(1'b0, 32'h0, 1'b0, 8'h00, txr, 1'b0, 8'h00);
    endtask

    task automatic wr_byte(input logic [31:0] a, input logic [7:0] d, input logic txr);
        step(1'b1, a, 1'b1, d, txr, 1'b0, 8'h00);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, a, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [31:0] exp_cnt, asm, ra;
        logic [31:0] addrs[10];
        logic rw;
        addrs = '{32'h30000, 32'h30004, 32'h30005, 32'h30006, 32'h30007,
                  32'h30001, 32'h3FFFF, 32'h20000, 32'h10000, 32'hFFF30000};
        tbl[0] = '{1'b1, 32'h30000,    1'b0, 1'b1, 8'h7A, 1'b1, 8'h7A};
        tbl[1] = '{1'b1, 32'h30000,    1'b0, 1'b0, 8'h55, 1'b0, 8'h00};
        tbl[2] = '{1'b1, 32'h30000,    1'b0, 1'b1, 8'hC3, 1'b1, 8'hC3};
        tbl[3] = '{1'b0, 32'h30000,    1'b0, 1'b1, 8'h11, 1'b0, 8'hC3};
        tbl[4] = '{1'b1, 32'h20000,    1'b0, 1'b1, 8'h22, 1'b0, 8'hC3};
        tbl[5] = '{1'b1, 32'h30008,    1'b0, 1'b1, 8'h33, 1'b0, 8'h00};
        tbl[6] = '{1'b1, 32'hFFF30000, 1'b0, 1'b1, 8'hFF, 1'b1, 8'hFF};
        tbl[7] = '{1'b1, 32'h30000,    1'b1, 1'b1, 8'h44, 1'b0, 8'hFF};

        // Reset held: a live rx read must not pop, everything reads zero.
        rdy_in = 1'b1; mem_a = 32'h30000; rx_valid = 1'b1; rx_data = 8'h7A;
        #3;
        chk("rst_rx_pop", rx_pop, 1'b0);
        chk("rst_io_din", io_din, 8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_buf_full", io_buffer_full, 1'b0);
        chk("rst_prog_done", prog_done, 1'b0);
        @(negedge clk_in); @(negedge clk_in);
        rdy_in = 1'b0; rx_valid = 1'b0;
        rst_in = 1'b0;
        model_reset();

        foreach (tbl[i]) begin
            step(tbl[i].rdy, tbl[i].a, tbl[i].wr, 8'h00, 1'b0, tbl[i].rxv, tbl[i].rxd);
            chk($sformatf("tbl%0d_pop", i), last_pop, tbl[i].exp_pop);
            chk($sformatf("tbl%0d_din", i), io_din, tbl[i].exp_din);
        end

        // Zero filter on the data port.
        got.delete();
        wr_byte(32'h30000, 8'h41, 1'b1);
        wr_byte(32'h30000, 8'h00, 1'b1);
        wr_byte(32'h30000, 8'h42, 1'b1);
        repeat (4) idle(1'b1);
        chk("filt_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("filt_b0", got[0], 8'h41);
            chk("filt_b1", got[1], 8'h42);
        end

        // Fill with tx stalled, margin flag, overflow drop, in-order drain.
        for (int i = 1; i <= 16; i++) begin
            wr_byte(32'h30000, i[7:0], 1'b0);
            if (i == 13) chk("bfull_after13", io_buffer_full, 1'b0);
            if (i == 14) chk("bfull_after14", io_buffer_full, 1'b1);
        end
        wr_byte(32'h30000, 8'h99, 1'b0);
        got.delete();
        repeat (20) idle(1'b1);
        chk("drain_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            chk($sformatf("drain_b%0d", i), got[i], i + 1);

        // Push into a full FIFO while it pops in the same cycle.
        for (int i = 1; i <= 16; i++) wr_byte(32'h30000, i[7:0], 1'b0);
        wr_byte(32'h30000, 8'hAA, 1'b1);
        idle(1'b0);
        chk("full_pop_bfull", io_buffer_full, 1'b1);
        got.delete();
        repeat (20) idle(1'b1);
        chk("full_pop_count", got.size(), 16);
        if (got.size() == 16) begin
            chk("full_pop_first", got[0], 8'h02);
            chk("full_pop_last", got[15], 8'hAA);
        end

        // Asynchronous reset mid-cycle with bytes queued and io_din nonzero.
        for (int i = 0; i < 3; i++) wr_byte(32'h30000, 8'h60 + i[7:0], 1'b0);
        rdy_in = 1'b0; mem_wr = 1'b0;
        #2 rst_in = 1'b1;
        #1;
        chk("midrst_tx_valid", tx_valid, 1'b0);
        chk("midrst_io_din", io_din, 8'h00);
        chk("midrst_bfull", io_buffer_full, 1'b0);
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        idle(1'b1);
        rd(32'h30004);
        chk("cnt_first_edge", io_din, 8'h01);

        // Snapshot consistency across the four byte reads.
        repeat (300) idle(1'b0);
        exp_cnt = m_cnt;
        rd(32'h30004); asm[7:0]   = io_din;
        rd(32'h30005); asm[15:8]  = io_din;
        rd(32'h30006); asm[23:16] = io_din;
        rd(32'h30007); asm[31:24] = io_din;
        chk("snapshot", asm, exp_cnt);
        repeat (20) idle(1'b0);
        rd(32'h30005);
        chk("snapshot_hold", io_din, exp_cnt[15:8]);

        // Random traffic against the model (stop register writes withheld).
        for (int n = 0; n < 400; n++) begin
            ra = addrs[$urandom_range(0, 9)];
            rw = 1'($urandom);
            if (rw && ra[17:0] == 18'h30004) rw = 1'b0;
            step(($urandom % 4) != 0, ra, rw, (($urandom % 4) == 0) ? 8'h00 : 8'($urandom),
                 1'($urandom), 1'($urandom), 8'($urandom));
        end

        // Stop write: flag set, 0x00 marker emitted, later writes ignored.
        repeat (20) idle(1'b1);
        got.delete();
        wr_byte(32'h30004, 8'h55, 1'b0);
        chk("stop_flag", prog_done, 1'b1);
        chk("stop_marker_valid", tx_valid, 1'b1);
        chk("stop_marker_data", tx_data, 8'h00);
        wr_byte(32'h30000, 8'h41, 1'b0);
        repeat (5) idle(1'b1);
        chk("stop_count", got.size(), 1);
        if (got.size() == 1) chk("stop_byte", got[0], 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/io_port_ctrl.md
IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 Parameter FIFO_AW, default 4, sets tx FIFO depth to 2**FIFO_AW entries.
REQ-002 Parameter FULL_MARGIN, default 2, is the free-entry count at or below which io_buffer_full asserts.
REQ-003 clk_in  input  1  sole clock, rising edge.
REQ-004 rst_in  input  1  asynchronous, active-high reset.
REQ-005 rdy_in  input  1  access enable; when low, CPU accesses are ignored.
REQ-006 mem_a  input  32  CPU address bus; only bits 17:0 are decoded.
REQ-007 mem_dout  input  8  CPU write data.
REQ-008 mem_wr  input  1  1 = write, 0 = read.
REQ-009 io_din  output  8  registered read data returned to the CPU.
REQ-010 io_buffer_full  output  1  tx FIFO nearly full; CPU must stall output writes.
REQ-011 tx_data / tx_valid / tx_ready  output 8 / output 1 / input 1  byte stream to the UART transmitter.
REQ-012 rx_data / rx_valid / rx_pop  input 8 / input 1 / output 1  byte source from the UART receiver.
REQ-013 prog_done  output  1  sticky program-stop flag.

Function
REQ-014 An IO access is any cycle with rdy_in=1 and mem_a[17:16]=2'b11; all other cycles are ignored.
REQ-015 Write to 0x30000 with mem_dout!=0 pushes mem_dout into the tx FIFO; a write of 0x00 is dropped.
REQ-016 Write to 0x30004 sets prog_done and pushes 0x00 into the tx FIFO, bypassing the zero filter.
REQ-017 After prog_done is set, all further IO writes are ignored.
REQ-018 A push to a full FIFO is dropped, unless a pop occurs in the same cycle, in which case the push is accepted.
REQ-019 FIFO pointers are FIFO_AW+1 bits and wrap modulo 2**(FIFO_AW+1).
- empty: pointers equal.
- full: indices equal and MSBs differ.
REQ-020 tx_valid = !empty; tx_data = head entry, combinational from storage.
REQ-021 A pop occurs on any cycle with tx_valid && tx_ready, independent of rdy_in.
REQ-022 io_buffer_full = (free entries <= FULL_MARGIN); it is registered and updated every cycle from next-state occupancy.
REQ-023 Cycle counter: 32-bit, increments every clock from reset, wraps 0xFFFFFFFF to 0, and ignores rdy_in.
REQ-024 Read of 0x30000 pulses rx_pop combinationally that cycle if rx_valid=1.
- Next cycle io_din = the captured rx_data, or 0x00 if rx_valid was 0.
REQ-025 Read of 0x30004 latches the counter value into a 32-bit snapshot register; next cycle io_din = that value's bits 7:0.
REQ-026 Reads of 0x30005, 0x30006 and 0x30007 return snapshot bytes 1, 2 and 3 next cycle; the snapshot is not refreshed.
REQ-027 Reads of other IO addresses return 0x00 next cycle.
REQ-028 Read latency is exactly 1 cycle; io_din holds its value until the next IO read.
REQ-029 Reads never touch the tx FIFO.

Reset
REQ-030 While rst_in=1, all of the following are held at 0:
- io_din, io_buffer_full, tx_valid, rx_pop, prog_done;
- FIFO pointers, counter, snapshot.
REQ-031 Reset asserted mid-operation discards FIFO contents immediately, with no partial pop.
REQ-032 On the first edge after reset release, the counter becomes 1.

Verification
REQ-033 Bench: write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx stream emits 0x41 then 0x42, with no 0x00.
REQ-034 Bench: tx_ready=0, FIFO_AW=4; write 16 nonzero bytes.
- io_buffer_full rises after the 14th accepted write.
- The 17th write is dropped.
- Releasing tx_ready drains exactly 16 bytes, in order.
REQ-035 Bench: FIFO full; write with tx_ready=1 in the same cycle -> write accepted, occupancy stays 16.
REQ-036 Bench: run 300 cycles after reset, read 0x30004..0x30007 -> the 4 bytes assemble to the counter value at the 0x30004 read, unchanged by later cycles.
REQ-037 Bench: write 0x55 to 0x30004 -> prog_done=1, 0x00 emitted on tx, and a subsequent write of 0x41 to 0x30000 produces no output.
REQ-038 Bench: rx_valid=1, rx_data=0x7A, read 0x30000 -> rx_pop=1 that cycle, io_din=0x7A next cycle; with rx_valid=0 -> io_din=0x00 and no rx_pop.
